// File: rtl/rob_pkg.sv
// Shared definitions for the ROB completion path: bank count, busy-clear
// field layout, tag width helper and the branch-age kill compare.
package rob_pkg;

    localparam int NBANK  = 4;
    localparam int BANK_W = $clog2(NBANK);
    localparam int NPORT  = 4;

    // rst_busy layout: {en, slot, bank}
    localparam int RB_BANK_LSB = 0;
    localparam int RB_SLOT_LSB = BANK_W;

    function automatic int tag_w(input int wbank);
        return wbank + BANK_W;
    endfunction

    function automatic int rb_en_pos(input int wbank);
        return wbank + BANK_W;
    endfunction

    // True when the uop's mask is younger than (or under) the mispredicted
    // branch: distinct masks and forward distance below half the tag space.
    function automatic logic br_killed(input logic [31:0] mask,
                                       input logic [31:0] kmask,
                                       input int          wbrm);
        logic [31:0] wm;
        logic [31:0] d;
        wm = (32'd1 << wbrm) - 32'd1;
        d  = (mask - kmask) & wm;
        return ((mask & wm) != (kmask & wm)) &&
               (d < (32'd1 << (wbrm - 1)));
    endfunction

endpackage

// File: rtl/rob_cmpl_skid.sv
// cmpl_skid: per-source DEPTH-entry completion FIFO with branch-kill filter.
// Ports: req_i/tag_i/brmask_i in, ready_o, pop_i from arbiter, kill_i,
// valid_o/tag_o head for arbitration. Macro ROB_CMPL_BYPASS_EN lets a
// request into an empty buffer be presented in its accept cycle.
module cmpl_skid
    import rob_pkg::*;
#(
    parameter int TW    = 5,
    parameter int BW    = 4,
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic [TW-1:0] tag_i,
    input  logic [BW-1:0] brmask_i,
    input  logic          pop_i,
    input  logic [BW:0]   kill_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [TW-1:0] tag_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [BW-1:0] brm;
    } ent_t;

    ent_t          ent_q [DEPTH];
    ent_t          ent_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [DEPTH-1:0] kill_v;
    logic          in_kill;
    logic          push;
    logic          byp;

    assign ready_o = cnt_q < DEPTH_C;
    assign push    = req_i & ready_o;
    assign in_kill = kill_i[BW] &&
                     br_killed(32'(brmask_i), 32'(kill_i[BW-1:0]), BW);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            kill_v[i] = kill_i[BW] &&
                        br_killed(32'(ent_q[i].brm),
                                  32'(kill_i[BW-1:0]), BW);
        end
    end

`ifdef ROB_CMPL_BYPASS_EN
    assign byp = (cnt_q == '0) && push && !in_kill;
`else
    assign byp = 1'b0;
`endif

    // A killed head blocks the source for this cycle; it is gone next cycle.
    assign valid_o = ((cnt_q != '0) && !kill_v[0]) || byp;
    assign tag_o   = (cnt_q != '0) ? ent_q[0].tag : tag_i;

    // Compact survivors (not popped, not killed) then append the new entry.
    always_comb begin
        int n;
        n = 0;
        for (int j = 0; j < DEPTH; j++) ent_d[j] = ent_q[j];
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_q) && !kill_v[i] && !(i == 0 && pop_i)) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == n) ent_d[j] = ent_q[i];
                end
                n = n + 1;
            end
        end
        if (push && !in_kill && !(pop_i && byp)) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == n) ent_d[j] = '{tag: tag_i, brm: brmask_i};
            end
            n = n + 1;
        end
        cnt_d = CW'(n);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: rtl/rob_cmpl.sv
// rob_cmpl: gathers NSRC completion streams into 4 registered ROB busy-clear
// ports via per-source FIFOs and a round-robin multi-grant arbiter.
// Ports: i_req/i_tag/i_brmask/o_ready per source, i_kill, o_rst_busy0..3.
// Macro ROB_CMPL_BYPASS_EN enables 1-cycle bypass into empty buffers.
module rob_cmpl
    import rob_pkg::*;
#(
    parameter int WIDTH_BANK = 3,
    parameter int WIDTH_BRM  = 4,
    parameter int NSRC       = 6,
    parameter int DEPTH      = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NSRC-1:0]                 i_req,
    input  logic [NSRC*(WIDTH_BANK+2)-1:0]  i_tag,
    input  logic [NSRC*WIDTH_BRM-1:0]       i_brmask,
    output logic [NSRC-1:0]                 o_ready,
    input  logic [WIDTH_BRM:0]              i_kill,
    output logic [WIDTH_BANK+2:0]           o_rst_busy0,
    output logic [WIDTH_BANK+2:0]           o_rst_busy1,
    output logic [WIDTH_BANK+2:0]           o_rst_busy2,
    output logic [WIDTH_BANK+2:0]           o_rst_busy3
);

    localparam int TW     = tag_w(WIDTH_BANK);
    localparam int OW     = TW + 1;
    localparam int EN_POS = rb_en_pos(WIDTH_BANK);
    localparam int RRW    = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] valid;
    logic [NSRC-1:0] grant;
    logic [TW-1:0]   head_tag [NSRC];
    logic [OW-1:0]   port_d [NPORT];
    logic [OW-1:0]   port_q [NPORT];
    logic [RRW-1:0]  rr_q;
    logic [RRW-1:0]  rr_d;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        cmpl_skid #(
            .TW    (TW),
            .BW    (WIDTH_BRM),
            .DEPTH (DEPTH)
        ) u_skid (
            .clk_i    (i_clk),
            .rst_i    (i_rst),
            .req_i    (i_req[s]),
            .tag_i    (i_tag[s*TW +: TW]),
            .brmask_i (i_brmask[s*WIDTH_BRM +: WIDTH_BRM]),
            .pop_i    (grant[s]),
            .kill_i   (i_kill),
            .ready_o  (o_ready[s]),
            .valid_o  (valid[s]),
            .tag_o    (head_tag[s])
        );
    end

    // Scan sources starting at rr; first NPORT valid ones fill ports in order.
    always_comb begin
        int ng;
        int last;
        int idx;
        ng    = 0;
        last  = 0;
        idx   = 0;
        grant = '0;
        for (int p = 0; p < NPORT; p++) port_d[p] = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            for (int s = 0; s < NSRC; s++) begin
                if (s == idx && valid[s] && ng < NPORT) begin
                    grant[s] = 1'b1;
                    for (int p = 0; p < NPORT; p++) begin
                        if (p == ng) begin
                            port_d[p][EN_POS]   = 1'b1;
                            port_d[p][TW-1:0]   = head_tag[s];
                        end
                    end
                    ng   = ng + 1;
                    last = s;
                end
            end
        end
        rr_d = rr_q;
        if (ng != 0) rr_d = (last == NSRC - 1) ? '0 : RRW'(last + 1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_q <= '0;
            for (int p = 0; p < NPORT; p++) port_q[p] <= '0;
        end else begin
            rr_q <= rr_d;
            for (int p = 0; p < NPORT; p++) port_q[p] <= port_d[p];
        end
    end

    assign o_rst_busy0 = port_q[0];
    assign o_rst_busy1 = port_q[1];
    assign o_rst_busy2 = port_q[2];
    assign o_rst_busy3 = port_q[3];

endmodule

// File: tb/tb_rob_cmpl.sv
// Testbench for rob_cmpl: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_rob_cmpl;

    localparam int NSRC  = 6;
    localparam int DEPTH = 2;
`ifdef ROB_CMPL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  req;
    logic [29:0] tag;
    logic [23:0] brm;
    logic [4:0]  kill;
    logic [5:0]  rdy;
    logic [5:0]  b0, b1, b2, b3;
    logic [5:0]  bo [4];

    assign bo[0] = b0;
    assign bo[1] = b1;
    assign bo[2] = b2;
    assign bo[3] = b3;

    rob_cmpl #(
        .WIDTH_BANK (3),
        .WIDTH_BRM  (4),
        .NSRC       (NSRC),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_tag       (tag),
        .i_brmask    (brm),
        .o_ready     (rdy),
        .i_kill      (kill),
        .o_rst_busy0 (b0),
        .o_rst_busy1 (b1),
        .o_rst_busy2 (b2),
        .o_rst_busy3 (b3)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] t;
        logic [3:0] m;
    } ent_t;

    ent_t       q [NSRC][$];
    int         rr_m;
    logic [5:0] exp_o [4];
    logic [5:0] exp_rdy;
    int         seen [32];
    int         en_total;
    int         n_chk;
    int         n_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    function automatic bit mkill(input logic [3:0] m);
        int d;
        if (!kill[4]) return 1'b0;
        if (m == kill[3:0]) return 1'b0;
        d = (int'(m) - int'(kill[3:0]) + 16) % 16;
        return d < 8;
    endfunction

    // Reference: at each edge, rank sources from rr, grant first 4 whose
    // oldest entry is live, then pop, drop killed entries, append accepts.
    task automatic model_step();
        bit   gr  [NSRC];
        bit   byp [NSRC];
        bit   acc [NSRC];
        bit   elig;
        int   ng;
        int   last;
        int   s;
        ent_t in_e;
        ent_t nq [$];
        for (int p = 0; p < 4; p++) exp_o[p] = '0;
        if (rst) begin
            for (int i = 0; i < NSRC; i++) q[i].delete();
            rr_m    = 0;
            exp_rdy = '1;
            return;
        end
        ng   = 0;
        last = 0;
        for (int i = 0; i < NSRC; i++) begin
            gr[i]  = 1'b0;
            byp[i] = 1'b0;
            acc[i] = req[i] && (q[i].size() < DEPTH);
        end
        for (int k = 0; k < NSRC; k++) begin
            s    = (rr_m + k) % NSRC;
            in_e = {tag[s*5 +: 5], brm[s*4 +: 4]};
            if (q[s].size() > 0) begin
                elig = !mkill(q[s][0].m);
            end else begin
                elig   = BYP && acc[s] && !mkill(in_e.m);
                byp[s] = elig;
            end
            if (elig && ng < 4) begin
                gr[s]     = 1'b1;
                exp_o[ng] = {1'b1, (q[s].size() > 0) ? q[s][0].t : in_e.t};
                ng++;
                last = s;
            end
        end
        if (ng > 0) rr_m = (last + 1) % NSRC;
        for (int i = 0; i < NSRC; i++) begin
            in_e = {tag[i*5 +: 5], brm[i*4 +: 4]};
            if (gr[i] && q[i].size() > 0) void'(q[i].pop_front());
            nq = {};
            for (int j = 0; j < q[i].size(); j++) begin
                if (!mkill(q[i][j].m)) nq.push_back(q[i][j]);
            end
            q[i] = nq;
            if (acc[i] && !mkill(in_e.m) && !(gr[i] && byp[i]))
                q[i].push_back(in_e);
            exp_rdy[i] = q[i].size() < DEPTH;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("port%0d", p), 32'(bo[p]), 32'(exp_o[p]));
        end
        chk("ready", 32'(rdy), 32'(exp_rdy));
        for (int p = 0; p < 4; p++) begin
            if (bo[p][5]) begin
                seen[bo[p][4:0]]++;
                en_total++;
            end
        end
    endtask

    task automatic put(input int s, input logic [4:0] t, input logic [3:0] m);
        req[s]        = 1'b1;
        tag[s*5 +: 5] = t;
        brm[s*4 +: 4] = m;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [4:0] t0 [3];
    int         sent;
    int         cyc;
    bit         saw_nr;
    bit         rdy0;
    int         base0, base1, base2;

    initial begin
        n_chk    = 0;
        n_err    = 0;
        en_total = 0;
        rr_m     = 0;
        exp_rdy  = '1;
        for (int i = 0; i < 32; i++) seen[i] = 0;
        for (int p = 0; p < 4; p++) exp_o[p] = '0;
        rst  = 1'b1;
        req  = '0;
        tag  = '0;
        brm  = '0;
        kill = '0;
        #1;
        chk("rst_busy0", 32'(b0), 32'h0);
        chk("rst_busy3", 32'(b3), 32'h0);
        chk("rst_ready", 32'(rdy), 32'h3f);
        tick();
        rst = 1'b0;

        // single completion from source 2
        put(2, 5'b10101, 4'd3);
        tick();
        req = '0;
        repeat (LAT - 1) tick();
        chk("single_p0", 32'(b0), 32'b110101);
        chk("single_p1_en", 32'(b1[5]), 32'h0);
        chk("single_p3_en", 32'(b3[5]), 32'h0);

        // six-way contention from rr=0
        do_reset();
        for (int s = 0; s < NSRC; s++) put(s, 5'(s * 4 + 2), 4'd0);
        tick();
        req = '0;
        repeat (LAT - 1) tick();
        chk("cont_p0", 32'(b0), 32'h22);
        chk("cont_p1", 32'(b1), 32'h26);
        chk("cont_p2", 32'(b2), 32'h2a);
        chk("cont_p3", 32'(b3), 32'h2e);
        tick();
        chk("cont2_p0", 32'(b0), 32'h32);
        chk("cont2_p1", 32'(b1), 32'h36);
        chk("cont2_p2", 32'(b2), 32'h0);
        put(0, 5'd1, 4'd0);
        put(5, 5'd3, 4'd0);
        tick();
        req = '0;
        repeat (LAT - 1) tick();
        chk("rr0_p0", 32'(b0), 32'h21);
        chk("rr0_p1", 32'(b1), 32'h23);

        // backpressure on source 0 with others saturating, from rr=2
        do_reset();
        put(1, 5'b00001, 4'd0);
        tick();
        req = '0;
        repeat (3) tick();
        t0[0] = 5'd4;
        t0[1] = 5'd8;
        t0[2] = 5'd12;
        base0 = seen[4];
        base1 = seen[8];
        base2 = seen[12];
        sent   = 0;
        cyc    = 0;
        saw_nr = 1'b0;
        while (sent < 3 && cyc < 40) begin
            put(0, t0[sent], 4'd0);
            for (int s = 1; s < NSRC; s++)
                put(s, {3'(cyc), 2'(1 + s % 3)}, 4'd0);
            rdy0 = rdy[0];
            if (!rdy0) saw_nr = 1'b1;
            tick();
            if (rdy0) sent++;
            cyc++;
        end
        req = '0;
        repeat (8) tick();
        chk("bp_sent", 32'(sent), 32'd3);
        chk("bp_notready_seen", 32'(saw_nr), 32'd1);
        chk("bp_once_t4", 32'(seen[4] - base0), 32'd1);
        chk("bp_once_t8", 32'(seen[8] - base1), 32'd1);
        chk("bp_once_t12", 32'(seen[12] - base2), 32'd1);

        // kill: masks 5 (dropped) and 2 (kept) against kill mask 3
        base0 = seen[5'b01101];
        base1 = seen[5'b11010];
        put(1, 5'b01101, 4'd5);
        put(2, 5'b11010, 4'd2);
        kill = BYP ? 5'b10011 : 5'b00000;
        tick();
        req  = '0;
        kill = 5'b10011;
        tick();
        kill = '0;
        repeat (3) tick();
        chk("kill_m5_gone", 32'(seen[5'b01101] - base0), 32'd0);
        chk("kill_m2_kept", 32'(seen[5'b11010] - base1), 32'd1);

        // wraparound kill: mask 14 kills 1, keeps 6 and 14
        put(3, 5'd7, 4'd1);
        put(4, 5'd9, 4'd6);
        put(5, 5'd11, 4'd14);
        tick();
        req  = '0;
        kill = 5'b11110;
        tick();
        kill = '0;
        repeat (3) tick();

        // reset mid-stream with entries buffered
        for (int s = 0; s < NSRC; s++) put(s, 5'(s + 16), 4'd0);
        tick();
        for (int s = 0; s < NSRC; s++) put(s, 5'(s + 24), 4'd0);
        tick();
        req = '0;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_p0", 32'(b0), 32'h0);
        chk("midrst_p1", 32'(b1), 32'h0);
        chk("midrst_p2", 32'(b2), 32'h0);
        chk("midrst_p3", 32'(b3), 32'h0);
        chk("midrst_ready", 32'(rdy), 32'h3f);
        tick();
        rst   = 1'b0;
        base0 = en_total;
        repeat (5) tick();
        chk("postrst_no_en", 32'(en_total - base0), 32'd0);

        // mixed traffic with occasional kills
        for (int i = 0; i < 300; i++) begin
            req  = 6'($urandom);
            tag  = 30'($urandom);
            brm  = 24'($urandom);
            kill = ($urandom_range(0, 7) == 0) ? {1'b1, 4'($urandom)} : 5'b0;
            tick();
        end
        req  = '0;
        kill = '0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rob_cmpl.md
ROB_CMPL -- requirements
Module: rob_cmpl

Interface
REQ-001 Parameter WIDTH_BANK, default 3, log2 of ROB slots per bank.
REQ-002 Parameter WIDTH_BRM, default 4, branch-mask (branch tag counter) width.
REQ-003 Parameter NSRC, default 6, number of execution-unit completion sources.
REQ-004 Parameter DEPTH, default 2, buffer entries per source.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 i_clk  in  1  clock, all state on rising edge.
REQ-007 i_rst  in  1  asynchronous active-high reset.
REQ-008 i_req  in  NSRC  per-source completion valid.
REQ-009 i_tag  in  NSRC*(WIDTH_BANK+2)  per-source ROB tag {slot, bank[1:0]}, source s at [(s+1)*W-1:s*W].
REQ-010 i_brmask  in  NSRC*WIDTH_BRM  per-source branch mask of the completing uop.
REQ-011 o_ready  out  NSRC  per-source accept; transfer when i_req[s] & o_ready[s].
REQ-012 i_kill  in  WIDTH_BRM+1  {kill enable, kill mask}.
REQ-013 o_rst_busy0..o_rst_busy3  out  3+WIDTH_BANK each  {en, slot, bank[1:0]} busy-clear to the ROB.

Function
REQ-014 o_ready[s] SHALL equal (entries of source s < DEPTH); no combinational dependence on i_req or grants.
REQ-015 Each source buffer SHALL be FIFO; push and pop in the same cycle SHALL be allowed.
REQ-016 Each cycle the arbiter SHALL grant the oldest entry of up to 4 distinct non-empty sources, scanning round-robin from pointer rr.
REQ-017 Granted entries SHALL map to o_rst_busy0,1,2,3 in scan order; unused ports carry en=0.
REQ-018 rr SHALL advance to (last granted source + 1) mod NSRC; unchanged when nothing granted.
REQ-019 o_rst_busy registers SHALL load at the edge ending the grant cycle; grants popped at that edge.
REQ-020 Latency: accept at edge E -> en visible after edge E+1 (2 cycles from request cycle) when uncontended.
REQ-021 Kill drop rule: entry dropped when kill enable, brmask != kill mask, and (brmask - kill mask) mod 2^WIDTH_BRM < 2^(WIDTH_BRM-1).
REQ-022 In a kill cycle matching entries (buffered and being accepted) SHALL be removed at that edge and SHALL NOT be granted; their port slots carry en=0.
REQ-023 Non-matching entries in a kill cycle SHALL be granted normally.
REQ-024 No entry SHALL be lost or duplicated; each accepted, non-killed completion produces exactly one en pulse.
REQ-025 Two outputs in the same cycle SHALL never carry identical {slot, bank} unless sources delivered duplicates.

Reset
REQ-026 While i_rst high: all buffers empty, rr=0, o_rst_busy0..3 = 0, o_ready = all ones.
REQ-027 Reset mid-operation SHALL discard all buffered completions with no en pulse after release.

Configuration
REQ-028 Macro ROB_CMPL_BYPASS_EN defined: a request to an empty buffer SHALL be arbitration-eligible in its accept cycle (latency 1 cycle), ranked as that source's oldest entry.
REQ-029 Macro undefined: no bypass; entries eligible only from the cycle after acceptance (REQ-020).

Structure
REQ-030 Shared package rob_pkg SHALL hold NBANK=4, rst_busy field layout (en/slot/bank positions), tag width function, and the branch-age compare function of REQ-021.
REQ-031 One sub-module cmpl_skid SHALL implement the per-source DEPTH-entry FIFO with kill filtering; rob_cmpl instantiates NSRC copies plus arbiter.

Verification
REQ-032 Single: source 2 tag 0b10101, brmask 3 -> o_rst_busy0 = {1,3'b101,2'b01} 2 cycles later, others en=0.
REQ-033 Contention: all 6 sources request same cycle, rr=0 -> ports 0..3 carry sources 0..3; next cycle sources 4,5 on ports 0,1; rr then 0 (after 5).
REQ-034 Backpressure: source 0 sends 3 back-to-back with 5 others saturating -> o_ready[0]=0 after 2 buffered; all 3 eventually emitted once.
REQ-035 Kill: buffered masks 5 and 2, kill {1,4'd3} -> mask 5 entry never emitted, mask 2 entry emitted.
REQ-036 Reset mid-stream: assert i_rst with 4 entries buffered -> outputs 0 immediately, no en after release, o_ready all ones.
REQ-037 With ROB_CMPL_BYPASS_EN: single request into empty buffer -> en visible after first edge (1 cycle).
